// File: rtl/line_buffer.sv
// line_buffer: five-row sliding column window over a raster-order pixel stream.
//
// Four row memories hold the previous four rows of the current frame. For each
// accepted pixel at (row, col), the outputs present column col of rows row-4 .. row,
// oldest first. The registered outputs appear one cycle after the pixel is accepted.
//
// Ports:
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   d_in [DATA_W]       raster-order pixel stream, accepted when in_valid=1
//   in_valid            pixel strobe; there is no backpressure
//   d_out1..d_out5      window column: d_out1 = row r-4 (oldest), d_out5 = row r
//   out_valid           d_out1..d_out5 hold a complete, aligned column
//   frame_done          one-cycle pulse alongside the last column of a frame
//
// Build option:
//   LINE_BUFFER_COL_MASK_EN  when defined, out_valid is also suppressed for col < 4,
//                            so only columns with a full 5x5 neighbourhood are flagged.

module line_buffer #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_in,
   input  logic              in_valid,
   output logic [DATA_W-1:0] d_out1,
   output logic [DATA_W-1:0] d_out2,
   output logic [DATA_W-1:0] d_out3,
   output logic [DATA_W-1:0] d_out4,
   output logic [DATA_W-1:0] d_out5,
   output logic              out_valid,
   output logic              frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;

   // m3 holds the most recent row, m0 the oldest; contents are never reset.
   logic [DATA_W-1:0] m0 [IMG_W];
   logic [DATA_W-1:0] m1 [IMG_W];
   logic [DATA_W-1:0] m2 [IMG_W];
   logic [DATA_W-1:0] m3 [IMG_W];

   logic col_last;
   logic row_last;
   logic row_ready;
   logic win_valid;

   assign col_last  = (col_q == COL_W'(IMG_W - 1));
   assign row_last  = (row_q == ROW_W'(IMG_H - 1));
   // Rows 0..3 of a frame only prime the memories, so anything older is never shown.
   assign row_ready = (row_q >= ROW_W'(4));

`ifdef LINE_BUFFER_COL_MASK_EN
   assign win_valid = row_ready && (col_q >= COL_W'(4));
`else
   assign win_valid = row_ready;
`endif

   // Counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         d_out1     <= '0;
         d_out2     <= '0;
         d_out3     <= '0;
         d_out4     <= '0;
         d_out5     <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else if (in_valid) begin
         d_out5     <= d_in;
         d_out4     <= m3[col_q];
         d_out3     <= m2[col_q];
         d_out2     <= m1[col_q];
         d_out1     <= m0[col_q];
         out_valid  <= win_valid;
         frame_done <= row_last && col_last;
         if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + ROW_W'(1);
         end else begin
            col_q <= col_q + COL_W'(1);
         end
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end
   end

   // Column shift through the row memories; all reads see pre-edge contents.
   always_ff @(posedge clk) begin
      if (!rst && in_valid) begin
         m3[col_q] <= d_in;
         m2[col_q] <= m3[col_q];
         m1[col_q] <= m2[col_q];
         m0[col_q] <= m1[col_q];
      end
   end

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: randomized and directed stimulus for line_buffer (6x6 frames),
// checked every cycle against a frame-array reference model, with literal
// expectations on the captured valid beats for the directed streams.

module tb_line_buffer;

   localparam int DW = 32;
   localparam int W  = 6;
   localparam int H  = 6;
   localparam int BW = 5 * DW;

`ifdef LINE_BUFFER_COL_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] d_in;
   logic [DW-1:0] d_out1, d_out2, d_out3, d_out4, d_out5;
   logic          out_valid;
   logic          frame_done;

   always #5 clk = ~clk;

   line_buffer #(
      .DATA_W (DW),
      .IMG_W  (W),
      .IMG_H  (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .d_in       (d_in),
      .in_valid   (in_valid),
      .d_out1     (d_out1),
      .d_out2     (d_out2),
      .d_out3     (d_out3),
      .d_out4     (d_out4),
      .d_out5     (d_out5),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pixel index within the frame plus a picture of the frame so far.
   int            n_acc;
   logic [DW-1:0] img [H][W];
   bit            exp_valid;
   bit            exp_done;
   bit            exp_known;
   logic [DW-1:0] exp_d [5];
   bit            armed = 1'b0;

   logic [BW-1:0] beats [$];
   bit            dones [$];

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [BW-1:0] pack5(input int a, input int b, input int c, input int d,
                                           input int e);
      return {DW'(a), DW'(b), DW'(c), DW'(d), DW'(e)};
   endfunction

   // Compare process: checks the DUT against the model on every cycle.
   always @(negedge clk) begin
      if (armed) begin
         chk("out_valid", BW'(out_valid), BW'(exp_valid));
         chk("frame_done", BW'(frame_done), BW'(exp_done));
         if (exp_known)
            chk("window", {d_out1, d_out2, d_out3, d_out4, d_out5},
                {exp_d[0], exp_d[1], exp_d[2], exp_d[3], exp_d[4]});
         if (out_valid) begin
            beats.push_back({d_out1, d_out2, d_out3, d_out4, d_out5});
            dones.push_back(frame_done);
         end
      end
   end

   // One clock cycle of stimulus; the model advances on the same edge as the DUT.
   task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
      int rr;
      int cc;
      rst      = r;
      in_valid = v;
      d_in     = d;
      @(posedge clk);
      if (r) begin
         n_acc     = 0;
         exp_valid = 1'b0;
         exp_done  = 1'b0;
         exp_known = 1'b1;
         for (int k = 0; k < 5; k++) exp_d[k] = '0;
      end else if (v) begin
         rr = n_acc / W;
         cc = n_acc % W;
         img[rr][cc] = d;
         exp_valid = (rr >= 4) && (!MASK || cc >= 4);
         exp_done  = (rr == H - 1) && (cc == W - 1);
         // Before row 4 the outputs carry stale memory, which the model does not track.
         exp_known = (rr >= 4);
         if (rr >= 4)
            for (int k = 0; k < 5; k++) exp_d[k] = img[rr - 4 + k][cc];
         n_acc = (n_acc + 1) % (W * H);
      end else begin
         exp_valid = 1'b0;
         exp_done  = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n0, input int n1, input bit toggle);
      for (int n = n0; n <= n1; n++) begin
         step(1'b1, DW'(n), 1'b0);
         if (toggle) step(1'b0, $urandom, 1'b0);
      end
      step(1'b0, '0, 1'b0);
   endtask

   task automatic chk_beat(input string name, input int idx, input logic [BW-1:0] exp);
      if (idx < beats.size()) begin
         chk(name, beats[idx], exp);
      end else begin
         checks++;
         failures++;
         $display("FAIL %s actual=missing beat %0d (have %0d) required=%0h",
                  name, idx, beats.size(), exp);
      end
   endtask

   task automatic chk_frame(input string tag);
      int ndone;
      ndone = 0;
      foreach (dones[i]) if (dones[i]) ndone++;
      chk({tag, "_count"}, BW'(beats.size()), BW'(MASK ? 4 : 12));
      chk_beat({tag, "_first"}, 0, MASK ? pack5(4, 10, 16, 22, 28) : pack5(0, 6, 12, 18, 24));
      chk_beat({tag, "_last"}, beats.size() - 1, pack5(11, 17, 23, 29, 35));
      chk({tag, "_done_count"}, BW'(ndone), BW'(1));
      if (dones.size() > 0) chk({tag, "_done_last"}, BW'(dones[$]), BW'(1));
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      d_in     = '0;
      @(negedge clk);
      armed = 1'b1;
      step(1'b0, '0, 1'b1);
      step(1'b1, 32'hdead_beef, 1'b1);
      chk("reset_window", {d_out1, d_out2, d_out3, d_out4, d_out5}, '0);
      chk("reset_valid", BW'({out_valid, frame_done}), '0);

      // Continuous stream, one frame.
      beats.delete();
      dones.delete();
      run(0, 35, 1'b0);
      chk_frame("cont");

      // Same frame with in_valid toggling.
      beats.delete();
      dones.delete();
      run(0, 35, 1'b1);
      chk_frame("toggle");

      // Reset mid-frame after n=20, then a fresh frame.
      run(0, 20, 1'b0);
      step(1'b0, '0, 1'b1);
      chk("midrst_window", {d_out1, d_out2, d_out3, d_out4, d_out5}, '0);
      beats.delete();
      dones.delete();
      run(0, 35, 1'b0);
      chk_frame("midrst");

      // Two frames back to back.
      beats.delete();
      dones.delete();
      run(0, 71, 1'b0);
      chk("two_count", BW'(beats.size()), BW'(MASK ? 8 : 24));
      chk_beat("two_second_first", MASK ? 4 : 12,
               MASK ? pack5(40, 46, 52, 58, 64) : pack5(36, 42, 48, 54, 60));

      // Randomized traffic with occasional resets.
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 199) == 0);
      step(1'b0, '0, 1'b0);

      armed = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
